// File: rtl/uart_debug_pkg.sv
// Shared definitions for the UART debug front end.
// Holds the command code enum, the frame/byte-engine state encodings,
// reply constants and the command classification helpers.
// Optional build macro used by the top module: SERIAL_TIMEOUT_EN.
package uart_debug_pkg;

    typedef enum logic [3:0] {
        CMD_NONE        = 4'h0,
        CMD_MCU_PAUSE   = 4'h1,
        CMD_MCU_RESUME  = 4'h2,
        CMD_REG_READ    = 4'h3,
        CMD_REG_WRITE   = 4'h4,
        CMD_MEM_READ_W  = 4'h5,
        CMD_MEM_WRITE_W = 4'h6,
        CMD_MEM_READ_B  = 4'h7,
        CMD_MEM_WRITE_B = 4'h8,
        CMD_BP_ADD      = 4'h9,
        CMD_BP_REMOVE   = 4'hA,
        CMD_STATUS      = 4'hB
    } cmd_e;

    typedef enum logic [2:0] {
        FR_IDLE  = 3'd0,
        FR_ADDR  = 3'd1,
        FR_DATA  = 3'd2,
        FR_ISSUE = 3'd3,
        FR_WAIT  = 3'd4,
        FR_REPLY = 3'd5
    } frame_state_e;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_STOP      = 3'd3,
        RX_WAIT_HIGH = 3'd4
    } rx_state_e;

    typedef enum logic [0:0] {
        TX_IDLE = 1'b0,
        TX_SEND = 1'b1
    } tx_state_e;

    localparam logic [7:0] ACK_ERR    = 8'hFF;
    localparam int         WORD_BYTES = 4;

    // Commands 0x3..0xA carry a 32-bit address after the command byte.
    function automatic logic has_addr(input logic [3:0] c);
        has_addr = (c >= 4'h3) && (c <= 4'hA);
    endfunction

    // Write commands additionally carry a 32-bit data word.
    function automatic logic has_data(input logic [3:0] c);
        has_data = (c == CMD_REG_WRITE) || (c == CMD_MEM_WRITE_W) ||
                   (c == CMD_MEM_WRITE_B);
    endfunction

    // Read commands return the controller's read data before the ack byte.
    function automatic logic is_read(input logic [3:0] c);
        is_read = (c == CMD_REG_READ) || (c == CMD_MEM_READ_W) ||
                  (c == CMD_MEM_READ_B) || (c == CMD_STATUS);
    endfunction

    // Codes 0xC..0xF are not defined and are never issued.
    function automatic logic is_known(input logic [3:0] c);
        is_known = (c <= CMD_STATUS);
    endfunction

endpackage

// File: rtl/uart_debug_frontend_phy.sv
// uart_byte_phy: 8N1 byte receiver and transmitter with baud counters.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   srx                 - asynchronous serial input (idle high)
//   rx_data, rx_valid   - received byte and one-cycle strobe
//   tx_data, tx_start   - byte to send and start request (accepted when idle)
//   tx_busy             - transmitter is shifting a byte
//   stx                 - serial output (idle high)
module uart_byte_phy
    import uart_debug_pkg::*;
#(
    parameter int BIT_CYCLES = 4340
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       srx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       stx
);

    localparam int CNT_W = $clog2(BIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_CYCLES / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [1:0]       sync_r;
    logic             prev_r;
    rx_state_e        rx_state_r;
    logic [CNT_W-1:0] rx_cnt_r;
    logic [2:0]       rx_bit_r;
    logic [7:0]       rx_shift_r;
    logic [7:0]       rx_data_r;
    logic             rx_valid_r;

    tx_state_e        tx_state_r;
    logic [CNT_W-1:0] tx_cnt_r;
    logic [3:0]       tx_bit_r;
    logic [8:0]       tx_shift_r;
    logic             stx_r;

    assign rx_data  = rx_data_r;
    assign rx_valid = rx_valid_r;
    assign tx_busy  = (tx_state_r == TX_SEND);
    assign stx      = stx_r;

    // Receiver: synchroniser, start-bit check at half a bit, mid-bit sampling.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_r     <= 2'b11;
            prev_r     <= 1'b1;
            rx_state_r <= RX_IDLE;
            rx_cnt_r   <= '0;
            rx_bit_r   <= 3'd0;
            rx_shift_r <= 8'h00;
            rx_data_r  <= 8'h00;
            rx_valid_r <= 1'b0;
        end else begin
            sync_r     <= {sync_r[0], srx};
            prev_r     <= sync_r[1];
            rx_valid_r <= 1'b0;
            case (rx_state_r)
                RX_IDLE: begin
                    if (prev_r && !sync_r[1]) begin
                        rx_state_r <= RX_START;
                        rx_cnt_r   <= '0;
                    end
                end
                RX_START: begin
                    if (rx_cnt_r == HALF_LAST) begin
                        rx_cnt_r <= '0;
                        rx_bit_r <= 3'd0;
                        // A line that is high again was a glitch, not a start bit.
                        rx_state_r <= sync_r[1] ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_r <= rx_cnt_r + CNT_ONE;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_r == BIT_LAST) begin
                        rx_cnt_r   <= '0;
                        rx_shift_r <= {sync_r[1], rx_shift_r[7:1]};
                        if (rx_bit_r == 3'd7) begin
                            rx_state_r <= RX_STOP;
                        end else begin
                            rx_bit_r <= rx_bit_r + 3'd1;
                        end
                    end else begin
                        rx_cnt_r <= rx_cnt_r + CNT_ONE;
                    end
                end
                RX_STOP: begin
                    // Stop-bit value is deliberately not checked.
                    if (rx_cnt_r == BIT_LAST) begin
                        rx_cnt_r   <= '0;
                        rx_data_r  <= rx_shift_r;
                        rx_valid_r <= 1'b1;
                        rx_state_r <= RX_WAIT_HIGH;
                    end else begin
                        rx_cnt_r <= rx_cnt_r + CNT_ONE;
                    end
                end
                RX_WAIT_HIGH: begin
                    if (sync_r[1]) begin
                        rx_state_r <= RX_IDLE;
                    end
                end
                default: rx_state_r <= RX_IDLE;
            endcase
        end
    end

    // Transmitter: start bit, 8 data bits LSB first, stop bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state_r <= TX_IDLE;
            tx_cnt_r   <= '0;
            tx_bit_r   <= 4'd0;
            tx_shift_r <= 9'h1FF;
            stx_r      <= 1'b1;
        end else begin
            case (tx_state_r)
                TX_IDLE: begin
                    stx_r <= 1'b1;
                    if (tx_start) begin
                        tx_state_r <= TX_SEND;
                        tx_shift_r <= {1'b1, tx_data};
                        tx_cnt_r   <= '0;
                        tx_bit_r   <= 4'd0;
                        stx_r      <= 1'b0;
                    end
                end
                TX_SEND: begin
                    if (tx_cnt_r == BIT_LAST) begin
                        tx_cnt_r <= '0;
                        // tx_bit_r counts bit periods already completed.
                        if (tx_bit_r == 4'd9) begin
                            tx_state_r <= TX_IDLE;
                            stx_r      <= 1'b1;
                        end else begin
                            stx_r      <= tx_shift_r[0];
                            tx_shift_r <= {1'b1, tx_shift_r[8:1]};
                            tx_bit_r   <= tx_bit_r + 4'd1;
                        end
                    end else begin
                        tx_cnt_r <= tx_cnt_r + CNT_ONE;
                    end
                end
                default: tx_state_r <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_debug_frontend.sv
// uart_debug_frontend: decodes UART command frames for the RISC-V debugger,
// issues them to the debug controller and serialises the reply.
// Ports:
//   clk, reset              - clock, synchronous active-high reset
//   srx / stx               - serial receive / transmit lines (idle high)
//   cmd, addr, d_in         - decoded command, address and write data
//   out_valid               - one-cycle pulse: cmd/addr/d_in valid
//   ctrlr_busy              - controller executing a command
//   d_rd, error             - controller read data and failure flag
// Build macro: SERIAL_TIMEOUT_EN drops a partial frame after
// 16*10*BIT_CYCLES cycles without a byte in ADDR or DATA.
module uart_debug_frontend
    import uart_debug_pkg::*;
#(
    parameter int CLK_RATE = 50_000_000,
    parameter int BAUD     = 11520
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        srx,
    output logic        stx,
    output logic [3:0]  cmd,
    output logic [31:0] addr,
    output logic [31:0] d_in,
    output logic        out_valid,
    input  logic        ctrlr_busy,
    input  logic [31:0] d_rd,
    input  logic        error
);

    localparam int BIT_CYCLES = CLK_RATE / BAUD;
    localparam logic [1:0] WORD_LAST = 2'(WORD_BYTES - 1);
    localparam logic [2:0] READ_REPLY_LEN = 3'(WORD_BYTES + 1);

    logic [7:0]   rx_data_s;
    logic         rx_valid_s;
    logic         tx_busy_s;
    logic         timeout_hit_s;
    logic [7:0]   reply_byte_s;
    logic [7:0]   ack_byte_s;

    frame_state_e state_r;
    logic [3:0]   cmd_r;
    logic [31:0]  addr_r;
    logic [31:0]  d_in_r;
    logic         out_valid_r;
    logic [1:0]   byte_cnt_r;
    logic         wait_skip_r;
    logic [31:0]  rd_data_r;
    logic         err_r;
    logic [2:0]   reply_idx_r;
    logic [2:0]   reply_len_r;
    logic         tx_start_r;
    logic [7:0]   tx_data_r;

    assign cmd       = cmd_r;
    assign addr      = addr_r;
    assign d_in      = d_in_r;
    assign out_valid = out_valid_r;

    uart_byte_phy #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_phy (
        .clk      (clk),
        .reset    (reset),
        .srx      (srx),
        .rx_data  (rx_data_s),
        .rx_valid (rx_valid_s),
        .tx_data  (tx_data_r),
        .tx_start (tx_start_r),
        .tx_busy  (tx_busy_s),
        .stx      (stx)
    );

`ifdef SERIAL_TIMEOUT_EN
    localparam int TIMEOUT_CYCLES = 16 * 10 * BIT_CYCLES;
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] idle_cnt_r;

    // Inter-byte silence counter, live only while collecting arguments.
    always_ff @(posedge clk) begin
        if (reset) begin
            idle_cnt_r <= '0;
        end else if (((state_r != FR_ADDR) && (state_r != FR_DATA)) || rx_valid_s) begin
            idle_cnt_r <= '0;
        end else begin
            idle_cnt_r <= idle_cnt_r + TO_W'(1);
        end
    end

    assign timeout_hit_s = (idle_cnt_r == TO_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit_s = 1'b0;
`endif

    assign ack_byte_s = err_r ? ACK_ERR : {4'h0, cmd_r};

    // Reply byte select: read data MSB first, then the ack byte.
    always_comb begin
        reply_byte_s = ack_byte_s;
        if (reply_len_r == READ_REPLY_LEN) begin
            case (reply_idx_r)
                3'd0:    reply_byte_s = rd_data_r[31:24];
                3'd1:    reply_byte_s = rd_data_r[23:16];
                3'd2:    reply_byte_s = rd_data_r[15:8];
                3'd3:    reply_byte_s = rd_data_r[7:0];
                default: reply_byte_s = ack_byte_s;
            endcase
        end else begin
            reply_byte_s = ack_byte_s;
        end
    end

    // Frame FSM: collect bytes, issue to controller, send the reply.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= FR_IDLE;
            cmd_r       <= 4'h0;
            addr_r      <= 32'h0;
            d_in_r      <= 32'h0;
            out_valid_r <= 1'b0;
            byte_cnt_r  <= 2'd0;
            wait_skip_r <= 1'b0;
            rd_data_r   <= 32'h0;
            err_r       <= 1'b0;
            reply_idx_r <= 3'd0;
            reply_len_r <= 3'd0;
            tx_start_r  <= 1'b0;
            tx_data_r   <= 8'h00;
        end else begin
            out_valid_r <= 1'b0;
            case (state_r)
                FR_IDLE: begin
                    if (rx_valid_s) begin
                        cmd_r      <= rx_data_s[3:0];
                        byte_cnt_r <= 2'd0;
                        if (!is_known(rx_data_s[3:0])) begin
                            // Unknown codes bypass the controller: reply ACK_ERR only.
                            err_r       <= 1'b1;
                            reply_idx_r <= 3'd0;
                            reply_len_r <= 3'd1;
                            state_r     <= FR_REPLY;
                        end else if (has_addr(rx_data_s[3:0])) begin
                            state_r <= FR_ADDR;
                        end else begin
                            state_r <= FR_ISSUE;
                        end
                    end
                end
                FR_ADDR: begin
                    if (rx_valid_s) begin
                        addr_r <= {addr_r[23:0], rx_data_s};
                        if (byte_cnt_r == WORD_LAST) begin
                            byte_cnt_r <= 2'd0;
                            state_r    <= has_data(cmd_r) ? FR_DATA : FR_ISSUE;
                        end else begin
                            byte_cnt_r <= byte_cnt_r + 2'd1;
                        end
                    end else if (timeout_hit_s) begin
                        state_r <= FR_IDLE;
                    end
                end
                FR_DATA: begin
                    if (rx_valid_s) begin
                        d_in_r <= {d_in_r[23:0], rx_data_s};
                        if (byte_cnt_r == WORD_LAST) begin
                            byte_cnt_r <= 2'd0;
                            state_r    <= FR_ISSUE;
                        end else begin
                            byte_cnt_r <= byte_cnt_r + 2'd1;
                        end
                    end else if (timeout_hit_s) begin
                        state_r <= FR_IDLE;
                    end
                end
                FR_ISSUE: begin
                    if (!ctrlr_busy) begin
                        out_valid_r <= 1'b1;
                        wait_skip_r <= 1'b1;
                        state_r     <= FR_WAIT;
                    end
                end
                FR_WAIT: begin
                    // The skipped cycle gives the controller time to raise busy.
                    if (wait_skip_r) begin
                        wait_skip_r <= 1'b0;
                    end else if (!ctrlr_busy) begin
                        rd_data_r   <= d_rd;
                        err_r       <= error;
                        reply_idx_r <= 3'd0;
                        reply_len_r <= is_read(cmd_r) ? READ_REPLY_LEN : 3'd1;
                        state_r     <= FR_REPLY;
                    end
                end
                FR_REPLY: begin
                    // tx_busy rises the cycle after tx_start, so skip that cycle.
                    if (tx_start_r) begin
                        tx_start_r <= 1'b0;
                    end else if (!tx_busy_s) begin
                        if (reply_idx_r == reply_len_r) begin
                            state_r <= FR_IDLE;
                        end else begin
                            tx_data_r   <= reply_byte_s;
                            tx_start_r  <= 1'b1;
                            reply_idx_r <= reply_idx_r + 3'd1;
                        end
                    end
                end
                default: state_r <= FR_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_debug_frontend.sv
// Self-checking bench for uart_debug_frontend: a table of directed frames,
// hand-written sequences for reset mid-frame and bytes arriving while busy,
// and random frames checked against a rule-level reference model.
module tb_uart_debug_frontend;

    localparam int CLK_RATE = 1_600_000;
    localparam int BAUD     = 100_000;
    localparam int BITC     = CLK_RATE / BAUD;
    localparam int LIMIT    = 20000;

    logic        clk = 1'b0;
    logic        reset;
    logic        srx;
    logic        stx;
    logic [3:0]  cmd;
    logic [31:0] addr;
    logic [31:0] d_in;
    logic        out_valid;
    logic        ctrlr_busy;
    logic [31:0] d_rd;
    logic        error;

    int n_vec  = 0;
    int n_miss = 0;
    int cfg_busy_len = 0;

    logic [7:0]  rep_q[$];
    logic [3:0]  iss_cmd[$];
    logic [31:0] iss_addr[$];
    logic [31:0] iss_din[$];
    logic [7:0]  mon_b;

    typedef struct {
        string       name;
        logic [71:0] frame;   // right-aligned, first byte most significant
        int          nbytes;
        int          busy_len;
        logic [31:0] rd;
        logic        err;
        logic        iss;
        logic [3:0]  ecmd;
        logic [31:0] eaddr;
        logic [31:0] edin;
        logic        ca;
        logic        cd;
        logic [39:0] rep;     // right-aligned, first byte most significant
        int          nrep;
    } vec_t;

    vec_t vecs[10];

    uart_debug_frontend #(.CLK_RATE(CLK_RATE), .BAUD(BAUD)) dut (
        .clk        (clk),
        .reset      (reset),
        .srx        (srx),
        .stx        (stx),
        .cmd        (cmd),
        .addr       (addr),
        .d_in       (d_in),
        .out_valid  (out_valid),
        .ctrlr_busy (ctrlr_busy),
        .d_rd       (d_rd),
        .error      (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        srx = 1'b0;
        repeat (BITC) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            srx = b[i];
            repeat (BITC) @(negedge clk);
        end
        srx = 1'b1;
        repeat (BITC) @(negedge clk);
    endtask

    // Decode bytes appearing on stx.
    initial begin
        forever begin
            @(negedge clk);
            if (stx === 1'b0) begin
                repeat (BITC / 2) @(negedge clk);
                if (stx === 1'b0) begin
                    for (int i = 0; i < 8; i++) begin
                        repeat (BITC) @(negedge clk);
                        mon_b[i] = stx;
                    end
                    repeat (BITC) @(negedge clk);
                    rep_q.push_back(mon_b);
                end
            end
        end
    end

    // Record every issued command.
    initial begin
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                iss_cmd.push_back(cmd);
                iss_addr.push_back(addr);
                iss_din.push_back(d_in);
            end
        end
    end

    // Controller model: busy for cfg_busy_len cycles after each issue.
    initial begin
        ctrlr_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1 && cfg_busy_len > 0) begin
                ctrlr_busy = 1'b1;
                repeat (cfg_busy_len) @(negedge clk);
                ctrlr_busy = 1'b0;
            end
        end
    end

    task automatic clear_queues();
        rep_q.delete();
        iss_cmd.delete();
        iss_addr.delete();
        iss_din.delete();
    endtask

    task automatic wait_reply(input int n, input string name);
        int t = 0;
        while (rep_q.size() < n && t < LIMIT) begin
            @(negedge clk);
            t++;
        end
        if (t >= LIMIT) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s.timeout: got %0d reply bytes expected %0d", name, rep_q.size(), n);
        end
        repeat (3 * BITC) @(negedge clk);
    endtask

    task automatic check_result(input string name, input logic iss, input logic [3:0] ecmd,
                                input logic [31:0] eaddr, input logic [31:0] edin,
                                input logic ca, input logic cd,
                                input logic [39:0] rep, input int nrep);
        chk({name, ".issued"}, 32'(iss_cmd.size()), iss ? 32'd1 : 32'd0);
        if (iss && iss_cmd.size() > 0) begin
            chk({name, ".cmd"}, {28'h0, iss_cmd[0]}, {28'h0, ecmd});
            if (ca) chk({name, ".addr"}, iss_addr[0], eaddr);
            if (cd) chk({name, ".d_in"}, iss_din[0], edin);
        end
        chk({name, ".nreply"}, 32'(rep_q.size()), 32'(nrep));
        for (int i = 0; i < nrep && i < rep_q.size(); i++) begin
            chk($sformatf("%s.reply%0d", name, i), {24'h0, rep_q[i]}, {24'h0, rep[8*(nrep-1-i) +: 8]});
        end
    endtask

    task automatic do_frame(input vec_t v);
        clear_queues();
        cfg_busy_len = v.busy_len;
        d_rd  = v.rd;
        error = v.err;
        for (int i = 0; i < v.nbytes; i++) begin
            send_byte(v.frame[8*(v.nbytes-1-i) +: 8]);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_reply(v.nrep, v.name);
        check_result(v.name, v.iss, v.ecmd, v.eaddr, v.edin, v.ca, v.cd, v.rep, v.nrep);
    endtask

    // Reference model: expected frame outcome from the command rules.
    task automatic make_random(input int k, output vec_t v);
        logic [7:0]  c;
        logic [3:0]  lo;
        logic [31:0] a;
        logic [31:0] d;
        logic        arg;
        logic        dat;
        logic        rd_cmd;
        logic        unknown;
        logic [7:0]  ack;
        c = 8'($urandom_range(0, 255));
        lo = c[3:0];
        a = $urandom;
        d = $urandom;
        unknown = (lo >= 4'd12);
        arg = (lo >= 4'd3) && (lo <= 4'd10);
        dat = (lo == 4'd4) || (lo == 4'd6) || (lo == 4'd8);
        rd_cmd = (lo == 4'd3) || (lo == 4'd5) || (lo == 4'd7) || (lo == 4'd11);
        v.name = $sformatf("rand%0d_c%0h", k, c);
        v.frame = {64'h0, c};
        v.nbytes = 1;
        if (arg) begin
            v.frame = {v.frame[39:0], a};
            v.nbytes += 4;
        end
        if (dat) begin
            v.frame = {v.frame[39:0], d};
            v.nbytes += 4;
        end
        v.busy_len = $urandom_range(0, 20);
        v.rd = $urandom;
        v.err = ($urandom_range(0, 3) == 0);
        v.iss = !unknown;
        v.ecmd = lo;
        v.eaddr = a;
        v.edin = d;
        v.ca = arg;
        v.cd = dat;
        ack = (v.err || unknown) ? 8'hFF : {4'h0, lo};
        if (unknown) begin
            v.rep = {32'h0, 8'hFF};
            v.nrep = 1;
        end else if (rd_cmd) begin
            v.rep = {v.rd, ack};
            v.nrep = 5;
        end else begin
            v.rep = {32'h0, ack};
            v.nrep = 1;
        end
    endtask

    initial begin
        vec_t rv;
        vecs[0] = '{"pause",      72'h01, 1, 0, 32'h0, 1'b0, 1'b1, 4'h1, 32'h0, 32'h0, 1'b0, 1'b0, 40'h01, 1};
        vecs[1] = '{"reg_write",  72'h04_00000005_DEADBEEF, 9, 3, 32'h0, 1'b0, 1'b1, 4'h4,
                    32'h5, 32'hDEADBEEF, 1'b1, 1'b1, 40'h04, 1};
        vecs[2] = '{"mem_read_w", 72'h05_00001000, 5, 10, 32'h12345678, 1'b0, 1'b1, 4'h5,
                    32'h1000, 32'h0, 1'b1, 1'b0, 40'h12_34_56_78_05, 5};
        vecs[3] = '{"reg_read_err", 72'h03_00000002, 5, 5, 32'hCAFEF00D, 1'b1, 1'b1, 4'h3,
                    32'h2, 32'h0, 1'b1, 1'b0, 40'hCA_FE_F0_0D_FF, 5};
        vecs[4] = '{"unknown_f",  72'h0F, 1, 0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 40'hFF, 1};
        vecs[5] = '{"status_hi",  72'hAB, 1, 2, 32'h000000A5, 1'b0, 1'b1, 4'hB,
                    32'h0, 32'h0, 1'b0, 1'b0, 40'h00_00_00_A5_0B, 5};
        vecs[6] = '{"none",       72'h00, 1, 0, 32'h0, 1'b0, 1'b1, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 40'h00, 1};
        vecs[7] = '{"unknown_c",  72'h5C, 1, 0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 40'hFF, 1};
        vecs[8] = '{"mem_wr_b_err", 72'h08_80000003_000000AA, 9, 0, 32'h0, 1'b1, 1'b1, 4'h8,
                    32'h80000003, 32'hAA, 1'b1, 1'b1, 40'hFF, 1};
        vecs[9] = '{"bp_add",     72'h09_00000040, 5, 1, 32'h0, 1'b0, 1'b1, 4'h9,
                    32'h40, 32'h0, 1'b1, 1'b0, 40'h09, 1};

        reset = 1'b1;
        srx   = 1'b1;
        d_rd  = 32'h0;
        error = 1'b0;
        repeat (5) @(negedge clk);
        chk("reset.stx", {31'h0, stx}, 32'h1);
        chk("reset.out_valid", {31'h0, out_valid}, 32'h0);
        chk("reset.cmd", {28'h0, cmd}, 32'h0);
        chk("reset.addr", addr, 32'h0);
        chk("reset.d_in", d_in, 32'h0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            do_frame(vecs[i]);
        end

        // A byte arriving while the controller is busy must be dropped.
        clear_queues();
        cfg_busy_len = 400;
        error = 1'b0;
        send_byte(8'h01);
        for (int t = 0; t < LIMIT && iss_cmd.size() == 0; t++) @(negedge clk);
        send_byte(8'h02);
        wait_reply(1, "drop_busy");
        repeat (4 * BITC) @(negedge clk);
        check_result("drop_busy", 1'b1, 4'h1, 32'h0, 32'h0, 1'b0, 1'b0, 40'h01, 1);

        // Reset in the middle of a MEM_WRITE_W frame aborts it.
        clear_queues();
        cfg_busy_len = 0;
        send_byte(8'h06);
        send_byte(8'h00);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midreset.cmd", {28'h0, cmd}, 32'h0);
        chk("midreset.stx", {31'h0, stx}, 32'h1);
        repeat (5) @(negedge clk);
        send_byte(8'h02);
        wait_reply(1, "midreset");
        check_result("midreset", 1'b1, 4'h2, 32'h0, 32'h0, 1'b0, 1'b0, 40'h02, 1);

        for (int k = 0; k < 12; k++) begin
            make_random(k, rv);
            do_frame(rv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/uart_debug_frontend.md
Name: uart_debug_frontend

Overview:
- UART front end of the RISC-V debugger.
- Receives command frames on a serial line (8N1, LSB first) and decodes them into a command, an address and a data word.
- Issues each decoded command to the debug controller with a valid/busy handshake, then serialises the read data and an acknowledge byte back on the transmit line.

Parameters:
- CLK_RATE, 50_000_000, system clock frequency in Hz.
- BAUD, 11520, serial bit rate.
- Derived: BIT_CYCLES = CLK_RATE/BAUD, which is 4340 with the defaults.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- srx  in  1  serial receive line; idle high; asynchronous, so it passes through a 2-flop synchroniser.
- stx  out  1  serial transmit line; idle high.
- cmd  out  4  decoded command.
- addr  out  32  decoded address.
- d_in  out  32  write data sent to the controller.
- out_valid  out  1  one-cycle pulse: cmd, addr and d_in are valid.
- ctrlr_busy  in  1  controller is executing a command.
- d_rd  in  32  read data from the controller.
- error  in  1  controller reports that the command failed.

Behaviour:
- Reset values: stx=1, out_valid=0, cmd=0, addr=0, d_in=0; receiver, transmitter and frame FSM go idle.
- Reset mid-frame aborts the frame.
- Receiver:
  - A falling edge while idle starts a byte.
  - Start bit is verified at BIT_CYCLES/2; if the line is high again, the byte is discarded.
  - Each data bit is sampled every BIT_CYCLES after that.
  - After bit 7 the receiver waits one bit period and ignores the stop-bit value.
  - It then waits for srx high before it will detect the next start bit.
- Transmitter: start bit 0, 8 data bits LSB first, stop bit 1, each lasting BIT_CYCLES.
- Frame formats (byte 0 is the command byte; cmd = byte[3:0], upper nibble ignored):
  - No-argument commands: command byte only.
  - Address commands: command byte, then 4 address bytes.
  - Address+data commands: command byte, 4 address bytes, then 4 data bytes.
  - All multi-byte words are sent MSB first.
- Frame FSM states and transitions:
  - IDLE: on command byte, go to ADDR if the command takes arguments, otherwise to ISSUE.
  - ADDR: after 4 bytes, go to DATA if the command takes data, otherwise to ISSUE.
  - DATA: after 4 bytes, go to ISSUE.
  - ISSUE: wait for ctrlr_busy=0, pulse out_valid for 1 cycle, go to WAIT.
  - WAIT: skip one cycle, then wait for ctrlr_busy=0; capture d_rd and error; go to REPLY.
  - REPLY: transmit reply bytes, then go to IDLE.
- cmd, addr and d_in hold stable from the out_valid pulse until REPLY completes.
- Reply bytes:
  - Read commands first send the 4 d_rd bytes, MSB first.
  - Every command then sends one ack byte: {4'h0,cmd} on success, 8'hFF if error was captured.
- An unknown cmd code (0xC–0xF) is not issued to the controller; the block replies 8'hFF only.
- Bytes received outside IDLE/ADDR/DATA (during ISSUE, WAIT or REPLY) are dropped.

Optional Feature:
- Macro: SERIAL_TIMEOUT_EN.
- Defined: in ADDR or DATA, if no byte arrives within 16×10×BIT_CYCLES, the partial frame is dropped and the FSM returns to IDLE with no reply.
- Undefined: the FSM waits indefinitely for the remaining bytes.

Decomposition:
- Package uart_debug_pkg holds:
  - cmd enum: 0 NONE, 1 MCU_PAUSE, 2 MCU_RESUME, 3 REG_READ, 4 REG_WRITE, 5 MEM_READ_W, 6 MEM_WRITE_W, 7 MEM_READ_B, 8 MEM_WRITE_B, 9 BP_ADD, A BP_REMOVE, B STATUS.
  - Functions has_addr() (true for 3–A) and has_data() (true for 4, 6, 8), and is_read(), which is true for REG_READ, MEM_READ_W, MEM_READ_B and STATUS.
  - Constants ACK_ERR=8'hFF and WORD_BYTES=4.
- One sub-module, uart_byte_phy, contains the rx and tx byte engines with their baud counters.
- The frame FSM stays in the top module.

Test Plan:
- MCU_PAUSE: send 0x01 -> out_valid pulses once with cmd=1; with ctrlr_busy held low, reply byte 0x01 on stx.
- REG_WRITE: send 04 00 00 00 05 DE AD BE EF -> cmd=4, addr=0x5, d_in=0xDEADBEEF at out_valid; reply 0x04.
- MEM_READ_W:
  - Stimulus: send 05 00 00 10 00; ctrlr_busy goes high for 10 cycles after out_valid; d_rd=0x12345678.
  - Required: reply 12 34 56 78 05.
- Controller error: REG_READ with error=1 when busy falls -> 4 d_rd bytes then 0xFF.
- Unknown command: send 0x0F -> no out_valid; reply 0xFF.
- Reset mid-frame:
  - Stimulus: send 06 00; assert reset for 1 cycle; then send 0x02.
  - Required: out_valid with cmd=2 only; reply 0x02.
